// File: rtl/nibble_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_pkg                                                   |
// | Description : Shared widths, lane state encoding and lane ids for the      |
// |               nibble assembler.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package nibble_pkg;

   localparam int NIBBLE_W = 4;
   localparam int NIBBLES  = 8;
   localparam int DATA_W   = NIBBLES * NIBBLE_W;
   localparam int CNT_W    = $clog2(NIBBLES);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } lane_state_t;

   localparam logic LANE_A = 1'b1;
   localparam logic LANE_B = 1'b0;

endpackage
`default_nettype wire

// File: rtl/nibble_assembler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_assembler_if                                          |
// | Description : Nibble input stream plus lane A/B word outputs.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface nibble_assembler_if;
   import nibble_pkg::*;

   logic                flush;
   logic                in_valid;
   logic                in_sel;
   logic [NIBBLE_W-1:0] nibble_in;
   logic                in_ready;
   logic [DATA_W-1:0]   dataA;
   logic                validA;
   logic                readyA;
   logic [DATA_W-1:0]   dataB;
   logic                validB;
   logic                readyB;

   modport master (
      output flush, in_valid, in_sel, nibble_in, readyA, readyB,
      input  in_ready, dataA, validA, dataB, validB
   );

   modport slave (
      input  flush, in_valid, in_sel, nibble_in, readyA, readyB,
      output in_ready, dataA, validA, dataB, validB
   );

endinterface
`default_nettype wire

// File: rtl/nibble_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_lane                                                  |
// | Description : One output lane: packs accepted nibbles into a word and      |
// |               holds it until the consumer takes it.                        |
// |               NIBBLE_MSB_FIRST_EN: first nibble lands in the top bits.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nibble_lane
   import nibble_pkg::*;
(
   input  wire logic                clk,
   input  wire logic                reset_L,
   input  wire logic                flush_i,
   input  wire logic                accept_i,
   input  wire logic [NIBBLE_W-1:0] nibble_i,
   input  wire logic                ready_i,
   output logic      [DATA_W-1:0]   data_o,
   output logic                     valid_o,
   output logic                     fill_o
);

   lane_state_t         state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   data_d;
   logic                valid_q;
   logic [CNT_W-1:0]    w_idx;

`ifdef NIBBLE_MSB_FIRST_EN
   assign w_idx = CNT_W'(NIBBLES - 1) - cnt_q;
`else
   assign w_idx = cnt_q;
`endif

   always_comb begin
      data_d = data_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (w_idx == CNT_W'(i)) begin
            data_d[i*NIBBLE_W +: NIBBLE_W] = nibble_i;
         end
      end
   end

   // cnt is already 0 in HOLD, so a drain+accept writes the first slot of the next word.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= FILL;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               if (flush_i) begin
                  cnt_q <= '0;
               end else if (accept_i) begin
                  data_q <= data_d;
                  if (cnt_q == CNT_W'(NIBBLES - 1)) begin
                     cnt_q   <= '0;
                     state_q <= HOLD;
                     valid_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= FILL;
                  if (accept_i) begin
                     data_q <= data_d;
                     cnt_q  <= CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= FILL;
               cnt_q   <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign fill_o  = (state_q == FILL);

endmodule
`default_nettype wire

// File: rtl/nibble_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_assembler                                             |
// | Description : Packs a nibble stream into 32-bit words on lane A or B,      |
// |               selected per nibble by in_sel (1=A, 0=B).                    |
// |               NIBBLE_MSB_FIRST_EN: first nibble goes to bits [31:28].      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nibble_assembler
   import nibble_pkg::*;
(
   input  wire logic          clk,
   input  wire logic          reset_L,
   nibble_assembler_if.slave  bus
);

   logic w_fill_a;
   logic w_fill_b;
   logic w_accept_a;
   logic w_accept_b;

   // A lane can take a nibble while filling, or while holding if its word drains now.
   assign bus.in_ready = ~bus.flush &
                         ((bus.in_sel == LANE_A) ? (w_fill_a | bus.readyA)
                                                 : (w_fill_b | bus.readyB));

   assign w_accept_a = bus.in_valid & bus.in_ready & (bus.in_sel == LANE_A);
   assign w_accept_b = bus.in_valid & bus.in_ready & (bus.in_sel == LANE_B);

   nibble_lane u_lane_a (
      .clk      (clk),
      .reset_L  (reset_L),
      .flush_i  (bus.flush),
      .accept_i (w_accept_a),
      .nibble_i (bus.nibble_in),
      .ready_i  (bus.readyA),
      .data_o   (bus.dataA),
      .valid_o  (bus.validA),
      .fill_o   (w_fill_a)
   );

   nibble_lane u_lane_b (
      .clk      (clk),
      .reset_L  (reset_L),
      .flush_i  (bus.flush),
      .accept_i (w_accept_b),
      .nibble_i (bus.nibble_in),
      .ready_i  (bus.readyB),
      .data_o   (bus.dataB),
      .valid_o  (bus.validB),
      .fill_o   (w_fill_b)
   );

endmodule
`default_nettype wire

// File: tb/tb_nibble_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nibble_assembler                                          |
// | Description : Directed scoreboard bench for nibble_assembler.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nibble_assembler;
   import nibble_pkg::*;

`ifdef NIBBLE_MSB_FIRST_EN
   localparam logic [31:0] W_1TO8 = 32'h12345678;
   localparam logic [31:0] W_F17  = 32'hF1234567;
   localparam logic [31:0] W_0TO7 = 32'h01234567;
`else
   localparam logic [31:0] W_1TO8 = 32'h87654321;
   localparam logic [31:0] W_F17  = 32'h7654321F;
   localparam logic [31:0] W_0TO7 = 32'h76543210;
`endif

   logic clk = 1'b0;
   logic reset_L;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] expA[$];
   logic [31:0] expB[$];
   logic [31:0] popA;
   logic [31:0] popB;

   nibble_assembler_if bus();

   nibble_assembler dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Caller sits just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic sel, input logic [3:0] nib);
      int t;
      bus.in_valid  = 1'b1;
      bus.in_sel    = sel;
      bus.nibble_in = nib;
      t = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         t++;
         if (t > 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles required 1", t);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset_L) begin
         if (bus.validA && bus.readyA) begin
            checks++;
            if (expA.size() == 0) begin
               errors++;
               $display("FAIL laneA_unexpected: got %h required no word", bus.dataA);
            end else begin
               popA = expA.pop_front();
               if (bus.dataA !== popA) begin
                  errors++;
                  $display("FAIL laneA_word: got %h required %h", bus.dataA, popA);
               end
            end
         end
         if (bus.validB && bus.readyB) begin
            checks++;
            if (expB.size() == 0) begin
               errors++;
               $display("FAIL laneB_unexpected: got %h required no word", bus.dataB);
            end else begin
               popB = expB.pop_front();
               if (bus.dataB !== popB) begin
                  errors++;
                  $display("FAIL laneB_word: got %h required %h", bus.dataB, popB);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 1'b0;
      bus.nibble_in = 4'h0;
      bus.readyA    = 1'b0;
      bus.readyB    = 1'b0;
      reset_L       = 1'b0;
      #12;
      chk("rst_dataA", bus.dataA, 32'h0);
      chk("rst_dataB", bus.dataB, 32'h0);
      chk("rst_validA", 32'(bus.validA), 32'h0);
      chk("rst_validB", 32'(bus.validB), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      reset_L = 1'b1;
      @(posedge clk);
      #1;

      // 1: eight nibbles to A, valid one cycle after the last, for one cycle
      bus.readyA = 1'b1;
      bus.readyB = 1'b1;
      expA.push_back(W_1TO8);
      for (int i = 1; i <= 8; i++) send(LANE_A, 4'(i));
      @(negedge clk);
      chk("t1_validA_latency", 32'(bus.validA), 32'h1);
      @(negedge clk);
      chk("t1_validA_one_cycle", 32'(bus.validA), 32'h0);
      @(posedge clk);
      #1;

      // 3: B held with readyB=0 blocks, then drain+accept in the same cycle
      bus.readyA = 1'b0;
      bus.readyB = 1'b0;
      for (int i = 1; i <= 8; i++) send(LANE_B, 4'(i));
      bus.in_valid  = 1'b1;
      bus.in_sel    = LANE_B;
      bus.nibble_in = 4'hF;
      repeat (3) begin
         @(negedge clk);
         chk("t3_blocked_in_ready", 32'(bus.in_ready), 32'h0);
      end
      chk("t3_held_dataB", bus.dataB, W_1TO8);
      chk("t3_held_validB", 32'(bus.validB), 32'h1);
      @(posedge clk);
      #1;
      expB.push_back(W_1TO8);
      expB.push_back(W_F17);
      bus.readyB = 1'b1;
      @(negedge clk);
      chk("t3_drain_in_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("t3_validB_after_drain", 32'(bus.validB), 32'h0);
      for (int i = 1; i <= 7; i++) send(LANE_B, 4'(i));
      repeat (2) @(posedge clk);
      #1;

      // 4: interleaved A/B traffic
      bus.readyA = 1'b1;
      bus.readyB = 1'b1;
      expA.push_back(32'hAAAAAAAA);
      expB.push_back(32'hBBBBBBBB);
      for (int i = 0; i < 8; i++) begin
         send(LANE_A, 4'hA);
         send(LANE_B, 4'hB);
      end
      repeat (2) @(posedge clk);
      #1;

      // 5: flush discards a partial A word; held B word survives
      bus.readyB = 1'b0;
      expB.push_back(32'h55555555);
      for (int i = 0; i < 8; i++) send(LANE_B, 4'h5);
      for (int i = 0; i < 3; i++) send(LANE_A, 4'h9);
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_sel    = LANE_A;
      bus.nibble_in = 4'hE;
      @(negedge clk);
      chk("t5_flush_in_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("t5_flush_validB", 32'(bus.validB), 32'h1);
      chk("t5_flush_dataB", bus.dataB, 32'h55555555);
      expA.push_back(W_0TO7);
      for (int i = 0; i < 8; i++) send(LANE_A, 4'(i));
      repeat (2) @(posedge clk);
      #1;
      bus.readyB = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 6: async reset mid-word and with B holding
      bus.readyA = 1'b0;
      bus.readyB = 1'b0;
      for (int i = 0; i < 8; i++) send(LANE_B, 4'h3);
      for (int i = 0; i < 5; i++) send(LANE_A, 4'h6);
      #2;
      reset_L = 1'b0;
      #1;
      chk("t6_async_validA", 32'(bus.validA), 32'h0);
      chk("t6_async_validB", 32'(bus.validB), 32'h0);
      chk("t6_async_dataA", bus.dataA, 32'h0);
      chk("t6_async_dataB", bus.dataB, 32'h0);
      @(negedge clk);
      #1;
      reset_L = 1'b1;
      @(posedge clk);
      #1;
      bus.readyA = 1'b1;
      bus.readyB = 1'b1;
      expA.push_back(W_1TO8);
      for (int i = 1; i <= 8; i++) send(LANE_A, 4'(i));
      repeat (4) @(posedge clk);
      #1;

      chk("sbA_drained", 32'(expA.size()), 32'h0);
      chk("sbB_drained", 32'(expB.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
